// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and the logic around it:
// the raw PLL lock in, the PLL reset, the staggered domain resets and status out.
interface pll_lock_sequencer_if #(
  parameter int NUM_RST = 3
);
  logic               pll_locked_in;
  logic               pll_rst_out;
  logic [NUM_RST-1:0] rst_out;
  logic               clock_lock;
  logic [7:0]         lock_lost_cnt;
  logic [7:0]         timeout_cnt;

  modport master (
    input  pll_locked_in,
    output pll_rst_out,
    output rst_out,
    output clock_lock,
    output lock_lost_cnt,
    output timeout_cnt
  );

  modport slave (
    output pll_locked_in,
    input  pll_rst_out,
    input  rst_out,
    input  clock_lock,
    input  lock_lost_cnt,
    input  timeout_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Resets a PLL, waits for a debounced lock, then releases per-domain resets
// one after another; any lock loss re-asserts every domain reset.
module pll_lock_sequencer #(
  parameter int NUM_RST       = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int PLL_RST_LEN   = 8,
  parameter int LOCK_DEBOUNCE = 16,
  parameter int STAGGER       = 4,
  parameter int TIMEOUT       = 1000
) (
  input  logic                 clock_in,
  input  logic                 rst_in,
  pll_lock_sequencer_if.master bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  localparam int CNT_MAX = imax(imax(PLL_RST_LEN, TIMEOUT), imax(LOCK_DEBOUNCE, STAGGER));
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(LOCK_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_DEBOUNCE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                 lock_s;
  logic                 pll_rst_q;
  logic [NUM_RST-1:0]   rst_q;
  logic [NUM_RST-1:0]   rst_next;
  logic                 clock_lock_q;
  logic [7:0]           lost_q;
  logic [7:0]           timeout_q;

  assign lock_s   = lock_sync[SYNC_STAGES-1];
  // Releasing the next domain is a left shift: 111 -> 110 -> 100 -> 000.
  assign rst_next = rst_q << 1;

  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      lock_sync    <= '0;
      state        <= S_PLL_RST;
      cnt          <= '0;
      pll_rst_q    <= 1'b1;
      rst_q        <= '1;
      clock_lock_q <= 1'b0;
      lost_q       <= 8'd0;
      timeout_q    <= 8'd0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked_in};
      case (state)
        S_PLL_RST: begin
          if (cnt == PLL_LAST) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state <= S_DEBOUNCE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            timeout_q <= sat_inc(timeout_q);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DEBOUNCE: begin
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= S_RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RELEASE: begin
          // Lock loss outranks a release or RUN entry due on this edge.
          if (!lock_s) begin
            state        <= S_WAIT_LOCK;
            cnt          <= '0;
            rst_q        <= '1;
            clock_lock_q <= 1'b0;
            lost_q       <= sat_inc(lost_q);
          end else if (rst_q[0] || (cnt == STG_LAST)) begin
            rst_q <= rst_next;
            cnt   <= '0;
            if (rst_next == '0) begin
              state        <= S_RUN;
              clock_lock_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state        <= S_WAIT_LOCK;
            cnt          <= '0;
            rst_q        <= '1;
            clock_lock_q <= 1'b0;
            lost_q       <= sat_inc(lost_q);
          end
        end
        default: begin
          state        <= S_PLL_RST;
          cnt          <= '0;
          pll_rst_q    <= 1'b1;
          rst_q        <= '1;
          clock_lock_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst_out   = pll_rst_q;
  assign bus.rst_out       = rst_q;
  assign bus.clock_lock    = clock_lock_q;
  assign bus.lock_lost_cnt = lost_q;
  assign bus.timeout_cnt   = timeout_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock traffic,
// all checked against a phase/elapsed-time model of the sequencer.
module tb_pll_lock_sequencer;

  localparam int NR = 3;
  localparam int SS = 2;
  localparam int PL = 8;
  localparam int LD = 16;
  localparam int ST = 4;
  localparam int TO = 1000;

  localparam int PH_PLL  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_DEB  = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RUN  = 4;

  logic clk;
  logic rst0, lock0;
  logic rst1, lock1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pll_lock_sequencer_if #(.NUM_RST(NR)) if0 ();
  pll_lock_sequencer_if #(.NUM_RST(2))  if1 ();
  assign if0.pll_locked_in = lock0;
  assign if1.pll_locked_in = lock1;

  pll_lock_sequencer u0 (
    .clock_in (clk),
    .rst_in   (rst0),
    .bus      (if0.master)
  );

  pll_lock_sequencer #(
    .NUM_RST(2), .SYNC_STAGES(3), .PLL_RST_LEN(2),
    .LOCK_DEBOUNCE(3), .STAGGER(1), .TIMEOUT(4)
  ) u1 (
    .clock_in (clk),
    .rst_in   (rst1),
    .bus      (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NR+17:0] got0;
  assign got0 = {if0.pll_rst_out, if0.rst_out, if0.clock_lock, if0.lock_lost_cnt, if0.timeout_cnt};

  // Model: phase, edges spent in the phase, domains released, event totals.
  int m_ph = PH_PLL, m_t = 0, m_rel = 0, m_lost = 0, m_to = 0;
  logic [SS-1:0] m_sync = '0;

  task automatic model_loss();
    m_ph = PH_WAIT; m_t = 0; m_rel = 0; m_lost++;
  endtask

  task automatic model_edge();
    logic ls;
    ls = m_sync[SS-1];
    if (rst0) begin
      m_ph = PH_PLL; m_t = 0; m_rel = 0; m_lost = 0; m_to = 0; m_sync = '0;
      return;
    end
    m_sync = {m_sync[SS-2:0], lock0};
    case (m_ph)
      PH_PLL: begin
        m_t++;
        if (m_t == PL) begin m_ph = PH_WAIT; m_t = 0; end
      end
      PH_WAIT: begin
        if (ls) begin m_ph = PH_DEB; m_t = 0; end
        else begin
          m_t++;
          if (m_t == TO) begin m_ph = PH_PLL; m_t = 0; m_to++; end
        end
      end
      PH_DEB: begin
        if (!ls) begin m_ph = PH_WAIT; m_t = 0; end
        else begin
          m_t++;
          if (m_t == LD) begin m_ph = PH_REL; m_t = 0; m_rel = 0; end
        end
      end
      PH_REL: begin
        if (!ls) model_loss();
        else begin
          m_t++;
          m_rel = 1 + (m_t - 1) / ST;
          if (m_rel >= NR) begin m_rel = NR; m_ph = PH_RUN; m_t = 0; end
        end
      end
      default: begin
        if (!ls) model_loss();
      end
    endcase
  endtask

  function automatic logic [NR+17:0] exp_vec();
    logic [NR-1:0] r;
    r = '1;
    r = r << m_rel;
    return {(m_ph == PH_PLL), r, (m_ph == PH_RUN),
            8'(m_lost > 255 ? 255 : m_lost), 8'(m_to > 255 ? 255 : m_to)};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; lock0 = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (got0 !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h exp=%h", got0, exp_vec());
    end
    n_checks++;
    if (if0.pll_rst_out !== 1'b1 || if0.rst_out !== 3'b111 || if0.clock_lock !== 1'b0 ||
        if0.lock_lost_cnt !== 8'd0 || if0.timeout_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", got0, {1'b1, 3'b111, 1'b0, 16'h0});
    end
  endtask

  task automatic test_bringup();
    int pll_hi, k110, k100, k000, klock;
    rst0 = 1'b0; lock0 = 1'b1;
    pll_hi = int'(if0.pll_rst_out);
    k110 = -1; k100 = -1; k000 = -1; klock = -1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      n_checks++;
      if (got0 !== exp_vec()) begin
        n_fail++; $display("FAIL bringup k=%0d got=%h exp=%h", k, got0, exp_vec());
      end
      if (if0.pll_rst_out === 1'b1) pll_hi++;
      if (if0.rst_out === 3'b110 && k110 < 0) k110 = k;
      if (if0.rst_out === 3'b100 && k100 < 0) k100 = k;
      if (if0.rst_out === 3'b000 && k000 < 0) k000 = k;
      if (if0.clock_lock === 1'b1 && klock < 0) klock = k;
    end
    n_checks++;
    if (pll_hi != PL) begin
      n_fail++; $display("FAIL pll_pulse_len got=%0d exp=%0d", pll_hi, PL);
    end
    n_checks++;
    if (k110 != PL + LD + 2 || k100 != k110 + ST || k000 != k110 + 2 * ST) begin
      n_fail++; $display("FAIL stagger_times got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                         k110, k100, k000, PL + LD + 2, PL + LD + 2 + ST, PL + LD + 2 + 2 * ST);
    end
    n_checks++;
    if (klock != k000) begin
      n_fail++; $display("FAIL clock_lock_rise got=%0d exp=%0d", klock, k000);
    end
  endtask

  task automatic test_glitch();
    int k110;
    rst0 = 1'b1; lock0 = 1'b1;
    repeat (2) tick();
    rst0 = 1'b0;
    k110 = -1;
    for (int k = 1; k <= 60; k++) begin
      lock0 = (k == 18) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if (got0 !== exp_vec()) begin
        n_fail++; $display("FAIL glitch k=%0d got=%h exp=%h", k, got0, exp_vec());
      end
      if (if0.rst_out === 3'b110 && k110 < 0) k110 = k;
    end
    n_checks++;
    if (k110 != 18 + SS + 1 + LD + 1 || if0.lock_lost_cnt !== 8'd0) begin
      n_fail++; $display("FAIL glitch_restart got=%0d/%0d exp=%0d/0", k110, if0.lock_lost_cnt,
                         18 + SS + 1 + LD + 1);
    end
  endtask

  task automatic test_lock_loss_run();
    n_checks++;
    if (if0.clock_lock !== 1'b1) begin
      n_fail++; $display("FAIL run_before_drop got=%b exp=1", if0.clock_lock);
    end
    for (int j = 0; j < 50; j++) begin
      lock0 = (j < 5) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if (got0 !== exp_vec()) begin
        n_fail++; $display("FAIL loss_run j=%0d got=%h exp=%h", j, got0, exp_vec());
      end
      if (j == SS - 1) begin
        n_checks++;
        if (if0.clock_lock !== 1'b1 || if0.rst_out !== 3'b000) begin
          n_fail++; $display("FAIL loss_early got=%b/%b exp=1/000", if0.clock_lock, if0.rst_out);
        end
      end
      if (j == SS) begin
        n_checks++;
        if (if0.clock_lock !== 1'b0 || if0.rst_out !== 3'b111 || if0.lock_lost_cnt !== 8'd1) begin
          n_fail++; $display("FAIL loss_react got=%b/%b/%0d exp=0/111/1",
                             if0.clock_lock, if0.rst_out, if0.lock_lost_cnt);
        end
      end
    end
    n_checks++;
    if (if0.clock_lock !== 1'b1 || if0.rst_out !== 3'b000 || if0.lock_lost_cnt !== 8'd1) begin
      n_fail++; $display("FAIL relock got=%b/%b/%0d exp=1/000/1",
                         if0.clock_lock, if0.rst_out, if0.lock_lost_cnt);
    end
  endtask

  task automatic test_rst_midrelease();
    int n;
    lock0 = 1'b0;
    tick();
    lock0 = 1'b1;
    n = 0;
    while (!(m_ph == PH_REL && m_rel == 2) && n < 100) begin
      tick();
      n++;
      n_checks++;
      if (got0 !== exp_vec()) begin
        n_fail++; $display("FAIL midrel_seq n=%0d got=%h exp=%h", n, got0, exp_vec());
      end
    end
    n_checks++;
    if (if0.rst_out !== 3'b100 || if0.lock_lost_cnt !== 8'd2) begin
      n_fail++; $display("FAIL midrel_reach got=%b/%0d exp=100/2", if0.rst_out, if0.lock_lost_cnt);
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    n_checks++;
    if (if0.rst_out !== 3'b111 || if0.pll_rst_out !== 1'b1 || if0.clock_lock !== 1'b0 ||
        if0.lock_lost_cnt !== 8'd0 || if0.timeout_cnt !== 8'd0 || got0 !== exp_vec()) begin
      n_fail++; $display("FAIL midrel_reset got=%h exp=%h", got0, {1'b1, 3'b111, 1'b0, 16'h0});
    end
  endtask

  task automatic test_drop_at_release();
    int kd;
    kd = PL + LD + 2 + 2 * ST - SS;
    rst0 = 1'b1; lock0 = 1'b1;
    repeat (2) tick();
    rst0 = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      lock0 = (k >= kd && k < kd + 4) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if (got0 !== exp_vec()) begin
        n_fail++; $display("FAIL drop_rel k=%0d got=%h exp=%h", k, got0, exp_vec());
      end
      if (k == kd + SS - 1) begin
        n_checks++;
        if (if0.rst_out !== 3'b100 || if0.clock_lock !== 1'b0) begin
          n_fail++; $display("FAIL drop_rel_pre got=%b/%b exp=100/0", if0.rst_out, if0.clock_lock);
        end
      end
      if (k == kd + SS) begin
        n_checks++;
        if (if0.rst_out !== 3'b111 || if0.clock_lock !== 1'b0 || if0.lock_lost_cnt !== 8'd1) begin
          n_fail++; $display("FAIL drop_rel_edge got=%b/%b/%0d exp=111/0/1",
                             if0.rst_out, if0.clock_lock, if0.lock_lost_cnt);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic ep;
    int   et;
    rst0 = 1'b1; lock0 = 1'b0;
    repeat (2) tick();
    rst0 = 1'b0;
    for (int k = 1; k <= 3 * (TO + PL) + 20; k++) begin
      tick();
      ep = ((k % (TO + PL)) < PL);
      et = k / (TO + PL);
      n_checks++;
      if (got0 !== exp_vec() || if0.pll_rst_out !== ep || if0.timeout_cnt !== 8'(et)) begin
        n_fail++; $display("FAIL timeout k=%0d got=%h exp=%h pll=%b/%b", k, got0, exp_vec(),
                           if0.pll_rst_out, ep);
      end
    end
  endtask

  task automatic test_timeout_sat();
    logic ep;
    int   et, ka, kb, n;
    rst1 = 1'b1; lock1 = 1'b0;
    repeat (2) tick();
    rst1 = 1'b0;
    for (int k = 1; k <= 256 * 6 + 12; k++) begin
      tick();
      ep = ((k % 6) < 2);
      et = (k / 6 > 255) ? 255 : k / 6;
      n_checks++;
      if (if1.pll_rst_out !== ep || if1.timeout_cnt !== 8'(et) || if1.rst_out !== 2'b11 ||
          if1.clock_lock !== 1'b0) begin
        n_fail++; $display("FAIL tsat k=%0d got=%b/%0d/%b exp=%b/%0d/11", k, if1.pll_rst_out,
                           if1.timeout_cnt, if1.rst_out, ep, et);
      end
    end
    lock1 = 1'b1;
    ka = -1; kb = -1; n = 0;
    while (if1.clock_lock !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (if1.rst_out === 2'b10 && ka < 0) ka = n;
      if (if1.rst_out === 2'b00 && kb < 0) kb = n;
    end
    n_checks++;
    if (if1.clock_lock !== 1'b1 || kb != ka + 1 || ka < 0 || if1.timeout_cnt !== 8'd255) begin
      n_fail++; $display("FAIL tsat_release got=%0d,%0d,%0d exp=step1,255", ka, kb, if1.timeout_cnt);
    end
  endtask

  task automatic test_random();
    int cyc;
    cyc = 0;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    while (cyc < 5000) begin
      int r, len;
      logic lv, rv;
      r  = int'($urandom_range(0, 99));
      rv = 1'b0;
      lv = lock0;
      if (r < 3) begin rv = 1'b1; len = int'($urandom_range(1, 2)); end
      else if (r < 50) begin lv = 1'b1; len = int'($urandom_range(1, 60)); end
      else if (r < 85) begin lv = 1'b0; len = int'($urandom_range(1, 6)); end
      else begin lv = 1'b0; len = int'($urandom_range(100, 1100)); end
      rst0 = rv; lock0 = lv;
      for (int i = 0; i < len; i++) begin
        tick();
        cyc++;
        n_checks++;
        if (got0 !== exp_vec()) begin
          n_fail++; $display("FAIL random c=%0d got=%h exp=%h", cyc, got0, exp_vec());
        end
      end
    end
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; lock0 = 1'b0;
    rst1 = 1'b1; lock1 = 1'b0;
    test_reset();
    test_bringup();
    test_glitch();
    test_lock_loss_run();
    test_rst_midrelease();
    test_drop_at_release();
    test_timeout();
    test_timeout_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_RST, default 3, giving the number of staggered reset outputs (legal 1..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth for pll_locked_in (legal 2..4).
REQ-003 The block SHALL have parameter PLL_RST_LEN, default 8, giving the pll_rst_out pulse length in cycles (legal >=1).
REQ-004 The block SHALL have parameter LOCK_DEBOUNCE, default 16, giving the consecutive synchronised-lock cycles required (legal >=1).
REQ-005 The block SHALL have parameter STAGGER, default 4, giving the cycles between successive rst_out releases (legal >=1).
REQ-006 The block SHALL have parameter TIMEOUT, default 1000, giving the WAIT_LOCK cycles before the PLL is re-reset (legal >=2).
REQ-007 clock_in  input  1  sole clock; all logic on its rising edge.
REQ-008 rst_in  input  1  reset, synchronous, active-high.
REQ-009 pll_locked_in  input  1  raw PLL lock (USR_PLL_LOCKED), asynchronous to clock_in.
REQ-010 pll_rst_out  output  1  reset request to the PLL, active-high.
REQ-011 rst_out  output  NUM_RST  per-domain resets, active-high; bit 0 releases first.
REQ-012 clock_lock  output  1  high only when all rst_out are released and lock is stable.
REQ-013 lock_lost_cnt  output  8  saturating count of lock losses after debounce.
REQ-014 timeout_cnt  output  8  saturating count of WAIT_LOCK timeouts.

Function
REQ-015 pll_locked_in SHALL pass through SYNC_STAGES flops; the last stage, lock_s, SHALL be the only lock signal used by the FSM (latency SYNC_STAGES cycles).
REQ-016 The FSM SHALL have the states PLL_RST, WAIT_LOCK, DEBOUNCE, RELEASE and RUN, with one shared cycle counter sized to the largest of PLL_RST_LEN, TIMEOUT, LOCK_DEBOUNCE and STAGGER.
REQ-017 PLL_RST: pll_rst_out=1 for exactly PLL_RST_LEN cycles, then WAIT_LOCK with counter=0.
REQ-018 WAIT_LOCK: if lock_s=1, go to DEBOUNCE with counter=0; else if counter=TIMEOUT-1, go to PLL_RST and increment timeout_cnt (saturating at 255); else increment the counter.
REQ-019 DEBOUNCE: if lock_s=0, go to WAIT_LOCK with counter=0 (no lock_lost_cnt change); if lock_s=1 and counter=LOCK_DEBOUNCE-1, go to RELEASE.
REQ-020 RELEASE: rst_out[0] SHALL fall on the first edge in RELEASE; rst_out[k] SHALL fall STAGGER*k cycles after rst_out[0]; once cleared, a bit SHALL stay cleared.
REQ-021 On the edge that clears rst_out[NUM_RST-1], the FSM SHALL enter RUN and clock_lock SHALL rise.
REQ-022 RUN: all outputs SHALL hold; the FSM SHALL not time out.
REQ-023 Lock loss: lock_s=0 in RELEASE or RUN SHALL, on the next edge, set rst_out to all ones, clear clock_lock, increment lock_lost_cnt (saturating at 255) and enter WAIT_LOCK with counter=0.
REQ-024 Lock loss SHALL take priority over a release or RUN entry due on the same edge.
REQ-025 pll_rst_out SHALL be 0 in every state except PLL_RST.
REQ-026 Counter arithmetic SHALL never wrap: the counter SHALL be cleared on every state change.
REQ-027 The 8-bit counters SHALL hold at 255.

Reset
REQ-028 rst_in=1 SHALL have priority over all other events on the same edge.
REQ-029 rst_in=1 SHALL produce, at the next edge: state=PLL_RST, counter=0, pll_rst_out=1, rst_out=all ones, clock_lock=0, lock_lost_cnt=0, timeout_cnt=0, synchroniser flops=0.
REQ-030 Assertion of rst_in mid-sequence, in any state, SHALL abort the sequence immediately with the same values as REQ-029.
REQ-031 After rst_in falls, the PLL_RST pulse SHALL run its full PLL_RST_LEN count.

Verification
REQ-032 Defaults, rst_in 1 for 3 cycles then 0, pll_locked_in=1 held -> pll_rst_out high 8 cycles; lock_s high 2 cycles after input; rst_out = 110, 100, 000 at 4-cycle steps after 16 debounce cycles; clock_lock=1 with rst_out=000.
REQ-033 pll_locked_in held 0 -> pll_rst_out re-pulses 8 cycles every 1000+8 cycles; timeout_cnt increments each time and reaches 255 and holds.
REQ-034 Lock glitches to 0 for 1 cycle at debounce count 10 -> FSM returns to WAIT_LOCK, lock_lost_cnt stays 0, debounce restarts and a full 16 stable cycles are needed.
REQ-035 In RUN, drop pll_locked_in for 5 cycles -> rst_out=111 and clock_lock=0 at SYNC_STAGES+1 cycles after the drop; lock_lost_cnt=1; the full re-release sequence occurs after relock.
REQ-036 rst_in pulsed 1 cycle while in RELEASE with rst_out=100 -> next cycle rst_out=111, pll_rst_out=1, counters=0.
REQ-037 Lock drops on the exact edge rst_out[2] is due to clear -> rst_out=111, clock_lock stays 0, lock_lost_cnt increments.
